// File: rtl/wb_simple_master_if.sv
// rtl/wb_simple_master_if.sv - Wishbone classic bus signals for the simple master
interface wb_simple_master_if;
  logic [31:0] ADR_O;
  logic [31:0] DAT_O;
  logic [31:0] DAT_I;
  logic [3:0]  SEL_O;
  logic        WE_O;
  logic        CYC_O;
  logic        STB_O;
  logic        LOCK_O;
  logic        ACK_I;
  logic        ERR_I;
  logic        RTY_I;

  modport master (
    output ADR_O, DAT_O, SEL_O, WE_O, CYC_O, STB_O, LOCK_O,
    input  DAT_I, ACK_I, ERR_I, RTY_I
  );

  modport slave (
    input  ADR_O, DAT_O, SEL_O, WE_O, CYC_O, STB_O, LOCK_O,
    output DAT_I, ACK_I, ERR_I, RTY_I
  );
endinterface

// File: rtl/wb_simple_master.sv
// rtl/wb_simple_master.sv - single-outstanding Wishbone classic master with retry and timeout
module wb_simple_master #(
  parameter int TIMEOUT   = 16,
  parameter int MAX_RETRY = 3,
  parameter int BACKOFF   = 2
) (
  input  logic                      p_clk,
  input  logic                      p_resetn,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic                      cmd_we,
  input  logic [31:0]               cmd_adr,
  input  logic [31:0]               cmd_dat,
  input  logic [3:0]                cmd_sel,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [31:0]               rsp_dat,
  output logic [1:0]                rsp_status,
  wb_simple_master_if.master        p_wb
);

  localparam int TW = $clog2(TIMEOUT);
  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam int BW = (BACKOFF > 1) ? $clog2(BACKOFF) : 1;

  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT - 1);
  localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);
  localparam logic [BW-1:0] BO_LAST   = BW'(BACKOFF - 1);

  localparam logic [1:0] ST_OK    = 2'b00;
  localparam logic [1:0] ST_ERR   = 2'b01;
  localparam logic [1:0] ST_TOUT  = 2'b10;
  localparam logic [1:0] ST_RETRY = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUS,
    S_BACKOFF,
    S_RESP
  } state_t;

  state_t state, state_nxt;

  logic [31:0]   adr_q;
  logic [31:0]   dat_q;
  logic [3:0]    sel_q;
  logic          we_q;
  logic          cyc_q;
  logic [TW-1:0] to_cnt;
  logic [RW-1:0] retry_cnt;
  logic [BW-1:0] bo_cnt;
  logic [31:0]   rsp_dat_q;
  logic [1:0]    rsp_status_q;

  always_ff @(posedge p_clk or negedge p_resetn) begin
    if (!p_resetn) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ERR beats ACK beats RTY; timeout only fires when nothing terminated.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (cmd_valid) begin
          state_nxt = S_BUS;
        end
      end
      S_BUS: begin
        if (p_wb.ERR_I || p_wb.ACK_I) begin
          state_nxt = S_RESP;
        end else if (p_wb.RTY_I) begin
          state_nxt = (retry_cnt < RETRY_MAX) ? S_BACKOFF : S_RESP;
        end else if (to_cnt == TO_LAST) begin
          state_nxt = S_RESP;
        end
      end
      S_BACKOFF: begin
        if (bo_cnt == BO_LAST) begin
          state_nxt = S_BUS;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    cmd_ready = 1'b0;
    rsp_valid = 1'b0;
    case (state)
      S_IDLE:  cmd_ready = 1'b1;
      S_RESP:  rsp_valid = 1'b1;
      default: ;
    endcase
  end

  // CYC/STB are a flop of the next state so the bus never sees decode glitches.
  always_ff @(posedge p_clk or negedge p_resetn) begin
    if (!p_resetn) begin
      adr_q        <= '0;
      dat_q        <= '0;
      sel_q        <= '0;
      we_q         <= 1'b0;
      cyc_q        <= 1'b0;
      to_cnt       <= '0;
      retry_cnt    <= '0;
      bo_cnt       <= '0;
      rsp_dat_q    <= '0;
      rsp_status_q <= ST_OK;
    end else begin
      cyc_q <= (state_nxt == S_BUS);
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            adr_q     <= cmd_adr;
            dat_q     <= cmd_dat;
            sel_q     <= cmd_sel;
            we_q      <= cmd_we;
            to_cnt    <= '0;
            retry_cnt <= '0;
          end
        end
        S_BUS: begin
          if (p_wb.ERR_I) begin
            rsp_status_q <= ST_ERR;
            rsp_dat_q    <= '0;
          end else if (p_wb.ACK_I) begin
            rsp_status_q <= ST_OK;
            rsp_dat_q    <= we_q ? 32'h0 : p_wb.DAT_I;
          end else if (p_wb.RTY_I) begin
            if (retry_cnt < RETRY_MAX) begin
              retry_cnt <= retry_cnt + 1'b1;
              bo_cnt    <= '0;
            end else begin
              rsp_status_q <= ST_RETRY;
              rsp_dat_q    <= '0;
            end
          end else if (to_cnt == TO_LAST) begin
            rsp_status_q <= ST_TOUT;
            rsp_dat_q    <= '0;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        S_BACKOFF: begin
          if (bo_cnt == BO_LAST) begin
            to_cnt <= '0;
          end else begin
            bo_cnt <= bo_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign p_wb.ADR_O  = adr_q;
  assign p_wb.DAT_O  = dat_q;
  assign p_wb.SEL_O  = sel_q;
  assign p_wb.WE_O   = we_q;
  assign p_wb.CYC_O  = cyc_q;
  assign p_wb.STB_O  = cyc_q;
  assign p_wb.LOCK_O = 1'b0;

  assign rsp_dat    = rsp_dat_q;
  assign rsp_status = rsp_status_q;

endmodule

// File: tb/tb_wb_simple_master.sv
// tb/tb_wb_simple_master.sv - scoreboard bench for wb_simple_master against a scripted slave
module tb_wb_simple_master;

  logic        p_clk;
  logic        p_resetn;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_we;
  logic [31:0] cmd_adr;
  logic [31:0] cmd_dat;
  logic [3:0]  cmd_sel;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_dat;
  logic [1:0]  rsp_status;

  wb_simple_master_if wb ();

  wb_simple_master dut (
    .p_clk      (p_clk),
    .p_resetn   (p_resetn),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_we     (cmd_we),
    .cmd_adr    (cmd_adr),
    .cmd_dat    (cmd_dat),
    .cmd_sel    (cmd_sel),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_dat    (rsp_dat),
    .rsp_status (rsp_status),
    .p_wb       (wb)
  );

  initial p_clk = 1'b0;
  always #5 p_clk = ~p_clk;

  typedef struct {
    logic [31:0] dat;
    logic [1:0]  st;
  } exp_t;

  exp_t        exp_q[$];
  int          acc_t[$];
  logic [31:0] p_adr[$];
  logic [31:0] p_dat[$];
  logic        p_we[$];
  int          gaps[$];

  int n_pass  = 0;
  int n_total = 0;
  int cyc_n   = 0;

  // slave script: 0 ack after ack_wait, 1 rty for first rty_n pulses then ack, 2 err+ack, 3 silent
  int          mode       = 0;
  int          ack_wait   = 0;
  int          rty_n      = 0;
  int          pulse_base = 0;
  logic [31:0] rd_data    = 32'h0;

  int   stb_cycles = 0;
  int   pulses     = 0;
  int   cur_len    = 0;
  int   low_run    = 0;
  logic stb_prev   = 1'b0;

  always @(posedge p_clk) cyc_n <= cyc_n + 1;

  always @(negedge p_clk) begin
    if (wb.STB_O) begin
      stb_cycles = stb_cycles + 1;
      if (!stb_prev) begin
        pulses = pulses + 1;
        p_adr.push_back(wb.ADR_O);
        p_dat.push_back(wb.DAT_O);
        p_we.push_back(wb.WE_O);
        gaps.push_back(low_run);
      end
      cur_len = cur_len + 1;
      low_run = 0;
    end else begin
      cur_len = 0;
      low_run = low_run + 1;
    end
    stb_prev = wb.STB_O;
  end

  always_comb begin
    wb.ACK_I = 1'b0;
    wb.ERR_I = 1'b0;
    wb.RTY_I = 1'b0;
    wb.DAT_I = rd_data;
    if (wb.STB_O && cur_len > 0) begin
      case (mode)
        0: wb.ACK_I = (cur_len > ack_wait);
        1: begin
          if (pulses - pulse_base <= rty_n) wb.RTY_I = 1'b1;
          else wb.ACK_I = 1'b1;
        end
        2: begin
          wb.ERR_I = 1'b1;
          wb.ACK_I = 1'b1;
        end
        default: ;
      endcase
    end
  end

  task automatic issue(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                       input logic [3:0] sel);
    bit ok = 0;
    @(negedge p_clk);
    for (int i = 0; i < 200; i++) begin
      if (cmd_ready) begin
        ok = 1;
        break;
      end
      @(negedge p_clk);
    end
    if (!ok) begin
      n_total++;
      $display("FAIL issue_timeout: cmd_ready=%0b required 1 within 200 cycles", cmd_ready);
    end else begin
      cmd_valid = 1'b1;
      cmd_we    = we;
      cmd_adr   = adr;
      cmd_dat   = dat;
      cmd_sel   = sel;
      @(posedge p_clk);
      #1;
      acc_t.push_back(cyc_n);
      cmd_valid = 1'b0;
    end
  endtask

  task automatic wait_rsp(output logic [31:0] d, output logic [1:0] s, output bit ok);
    ok = 0;
    d  = 'x;
    s  = 'x;
    for (int i = 0; i < 200; i++) begin
      @(negedge p_clk);
      if (rsp_valid) begin
        d  = rsp_dat;
        s  = rsp_status;
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      n_total++;
      $display("FAIL rsp_timeout: rsp_valid=%0b required 1 within 200 cycles", rsp_valid);
    end else if (rsp_ready) begin
      @(posedge p_clk);
      #1;
    end
  endtask

  task automatic test_reset();
    p_resetn  = 1'b0;
    cmd_valid = 1'b0;
    cmd_we    = 1'b0;
    cmd_adr   = '0;
    cmd_dat   = '0;
    cmd_sel   = '0;
    rsp_ready = 1'b1;
    repeat (3) @(negedge p_clk);
    p_resetn = 1'b1;
    repeat (2) @(negedge p_clk);
    n_total++;
    if ({wb.CYC_O, wb.STB_O, wb.WE_O, wb.LOCK_O} !== 4'b0000)
      $display("FAIL reset_ctl: cyc/stb/we/lock=%b required 0000",
               {wb.CYC_O, wb.STB_O, wb.WE_O, wb.LOCK_O});
    else n_pass++;
    n_total++;
    if (wb.ADR_O !== 32'h0) $display("FAIL reset_adr: got %h required 0", wb.ADR_O);
    else n_pass++;
    n_total++;
    if (wb.DAT_O !== 32'h0) $display("FAIL reset_dat_o: got %h required 0", wb.DAT_O);
    else n_pass++;
    n_total++;
    if (wb.SEL_O !== 4'h0) $display("FAIL reset_sel: got %h required 0", wb.SEL_O);
    else n_pass++;
    n_total++;
    if (cmd_ready !== 1'b1) $display("FAIL reset_cmd_ready: got %b required 1", cmd_ready);
    else n_pass++;
    n_total++;
    if ({rsp_valid, rsp_dat, rsp_status} !== 35'h0)
      $display("FAIL reset_rsp: valid=%b dat=%h st=%b required 0/0/00", rsp_valid, rsp_dat, rsp_status);
    else n_pass++;
  endtask

  task automatic test_write_ack();
    logic [31:0] d;
    logic [1:0]  s;
    bit          ok;
    exp_t        e;
    int          sb = stb_cycles;
    int          pb = p_adr.size();
    mode = 0; ack_wait = 0;
    exp_q.push_back('{dat: 32'h0, st: 2'b00});
    issue(1'b1, 32'hB000_0008, 32'hDEAD_BEEF, 4'hF);
    wait_rsp(d, s, ok);
    if (ok) begin
      e = exp_q.pop_front();
      n_total++;
      if (d !== e.dat || s !== e.st)
        $display("FAIL write_rsp: dat=%h st=%b required %h/%b", d, s, e.dat, e.st);
      else n_pass++;
    end
    n_total++;
    if (stb_cycles - sb !== 1) $display("FAIL write_stb_cycles: got %0d required 1", stb_cycles - sb);
    else n_pass++;
    n_total++;
    if (p_adr.size() != pb + 1 || p_adr[pb] !== 32'hB000_0008 || p_dat[pb] !== 32'hDEAD_BEEF || p_we[pb] !== 1'b1)
      $display("FAIL write_bus: pulses=%0d adr=%h dat=%h we=%b required 1/b0000008/deadbeef/1",
               p_adr.size() - pb, p_adr[pb], p_dat[pb], p_we[pb]);
    else n_pass++;
  endtask

  task automatic test_read_wait();
    logic [31:0] d;
    logic [1:0]  s;
    bit          ok;
    exp_t        e;
    int          sb = stb_cycles;
    mode = 0; ack_wait = 3; rd_data = 32'h1234_5678;
    exp_q.push_back('{dat: 32'h1234_5678, st: 2'b00});
    issue(1'b0, 32'hB000_0004, 32'h0, 4'hF);
    wait_rsp(d, s, ok);
    if (ok) begin
      e = exp_q.pop_front();
      n_total++;
      if (d !== e.dat || s !== e.st)
        $display("FAIL read_rsp: dat=%h st=%b required %h/%b", d, s, e.dat, e.st);
      else n_pass++;
    end
    n_total++;
    if (stb_cycles - sb !== 4) $display("FAIL read_stb_cycles: got %0d required 4", stb_cycles - sb);
    else n_pass++;
  endtask

  task automatic test_retry();
    logic [31:0] d;
    logic [1:0]  s;
    bit          ok;
    exp_t        e;
    int          pb = p_adr.size();
    pulse_base = pulses; mode = 1; rty_n = 2; rd_data = 32'h0BAD_F00D;
    exp_q.push_back('{dat: 32'h0BAD_F00D, st: 2'b00});
    issue(1'b0, 32'hB000_0010, 32'h0, 4'h3);
    wait_rsp(d, s, ok);
    if (ok) begin
      e = exp_q.pop_front();
      n_total++;
      if (d !== e.dat || s !== e.st)
        $display("FAIL retry_rsp: dat=%h st=%b required %h/%b", d, s, e.dat, e.st);
      else n_pass++;
    end
    n_total++;
    if (p_adr.size() - pb !== 3) $display("FAIL retry_pulses: got %0d required 3", p_adr.size() - pb);
    else n_pass++;
    if (p_adr.size() - pb == 3) begin
      n_total++;
      if (gaps[pb+1] !== 2 || gaps[pb+2] !== 2)
        $display("FAIL retry_gaps: got %0d,%0d required 2,2", gaps[pb+1], gaps[pb+2]);
      else n_pass++;
      n_total++;
      if (p_adr[pb] !== 32'hB000_0010 || p_adr[pb+1] !== 32'hB000_0010 || p_adr[pb+2] !== 32'hB000_0010)
        $display("FAIL retry_adr: got %h,%h,%h required b0000010", p_adr[pb], p_adr[pb+1], p_adr[pb+2]);
      else n_pass++;
    end
  endtask

  task automatic test_retry_exhaust();
    logic [31:0] d;
    logic [1:0]  s;
    bit          ok;
    exp_t        e;
    int          pb = pulses;
    pulse_base = pulses; mode = 1; rty_n = 100; rd_data = 32'hFFFF_FFFF;
    exp_q.push_back('{dat: 32'h0, st: 2'b11});
    issue(1'b0, 32'hB000_0014, 32'h0, 4'hF);
    wait_rsp(d, s, ok);
    if (ok) begin
      e = exp_q.pop_front();
      n_total++;
      if (d !== e.dat || s !== e.st)
        $display("FAIL exhaust_rsp: dat=%h st=%b required %h/%b", d, s, e.dat, e.st);
      else n_pass++;
    end
    n_total++;
    if (pulses - pb !== 4) $display("FAIL exhaust_pulses: got %0d required 4", pulses - pb);
    else n_pass++;
  endtask

  task automatic test_err_ack();
    logic [31:0] d;
    logic [1:0]  s;
    bit          ok;
    exp_t        e;
    int          pb = pulses;
    mode = 2; rd_data = 32'hCAFE_0001;
    exp_q.push_back('{dat: 32'h0, st: 2'b01});
    issue(1'b0, 32'hB000_0018, 32'h0, 4'hF);
    wait_rsp(d, s, ok);
    if (ok) begin
      e = exp_q.pop_front();
      n_total++;
      if (d !== e.dat || s !== e.st)
        $display("FAIL err_ack_rsp: dat=%h st=%b required %h/%b", d, s, e.dat, e.st);
      else n_pass++;
    end
    n_total++;
    if (pulses - pb !== 1) $display("FAIL err_ack_pulses: got %0d required 1", pulses - pb);
    else n_pass++;
  endtask

  task automatic test_timeout_hold();
    logic [31:0] d;
    logic [1:0]  s;
    bit          ok;
    exp_t        e;
    int          sb = stb_cycles;
    mode = 3; rsp_ready = 1'b0;
    exp_q.push_back('{dat: 32'h0, st: 2'b10});
    issue(1'b0, 32'hB000_001C, 32'h0, 4'hF);
    wait_rsp(d, s, ok);
    if (ok) begin
      e = exp_q.pop_front();
      n_total++;
      if (d !== e.dat || s !== e.st)
        $display("FAIL timeout_rsp: dat=%h st=%b required %h/%b", d, s, e.dat, e.st);
      else n_pass++;
      n_total++;
      if (stb_cycles - sb !== 16) $display("FAIL timeout_stb_cycles: got %0d required 16", stb_cycles - sb);
      else n_pass++;
      for (int i = 0; i < 5; i++) begin
        @(negedge p_clk);
        n_total++;
        if ({rsp_valid, cmd_ready, rsp_dat, rsp_status} !== {1'b1, 1'b0, e.dat, e.st})
          $display("FAIL hold_cycle%0d: valid=%b ready=%b dat=%h st=%b required 1/0/%h/%b",
                   i, rsp_valid, cmd_ready, rsp_dat, rsp_status, e.dat, e.st);
        else n_pass++;
      end
      rsp_ready = 1'b1;
      @(posedge p_clk);
      #1;
      n_total++;
      if (rsp_valid !== 1'b0) $display("FAIL handoff_valid: got %b required 0", rsp_valid);
      else n_pass++;
    end
    rsp_ready = 1'b1;
  endtask

  task automatic test_back_to_back();
    int ab = acc_t.size();
    mode = 0; ack_wait = 0; rsp_ready = 1'b1;
    fork
      begin
        for (int i = 0; i < 4; i++) begin
          exp_q.push_back('{dat: 32'h0, st: 2'b00});
          issue(1'b1, 32'hB000_0020 + 32'(i * 4), 32'h5A5A_0000 + 32'(i), 4'hF);
        end
      end
      begin
        for (int j = 0; j < 4; j++) begin
          logic [31:0] d;
          logic [1:0]  s;
          bit          ok;
          exp_t        e;
          wait_rsp(d, s, ok);
          if (ok && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_total++;
            if (d !== e.dat || s !== e.st)
              $display("FAIL b2b_rsp%0d: dat=%h st=%b required %h/%b", j, d, s, e.dat, e.st);
            else n_pass++;
          end
        end
      end
    join
    for (int k = 1; k < 4; k++) begin
      if (acc_t.size() > ab + k) begin
        n_total++;
        if (acc_t[ab+k] - acc_t[ab+k-1] !== 3)
          $display("FAIL b2b_spacing%0d: got %0d cycles required 3", k, acc_t[ab+k] - acc_t[ab+k-1]);
        else n_pass++;
      end
    end
  endtask

  task automatic test_reset_mid_bus();
    mode = 3;
    issue(1'b1, 32'hB000_0030, 32'h1111_2222, 4'hF);
    repeat (3) @(negedge p_clk);
    n_total++;
    if (wb.CYC_O !== 1'b1) $display("FAIL midbus_pre_cyc: got %b required 1", wb.CYC_O);
    else n_pass++;
    #2;
    p_resetn = 1'b0;
    #1;
    n_total++;
    if ({wb.CYC_O, wb.STB_O} !== 2'b00)
      $display("FAIL midbus_async_drop: cyc/stb=%b required 00", {wb.CYC_O, wb.STB_O});
    else n_pass++;
    @(negedge p_clk);
    p_resetn = 1'b1;
    @(negedge p_clk);
    n_total++;
    if ({cmd_ready, rsp_valid, wb.CYC_O} !== 3'b100)
      $display("FAIL midbus_after: ready/valid/cyc=%b required 100", {cmd_ready, rsp_valid, wb.CYC_O});
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_write_ack();
    test_read_wait();
    test_retry();
    test_retry_exhaust();
    test_err_ack();
    test_timeout_hold();
    test_back_to_back();
    test_reset_mid_bus();
    n_total++;
    if (exp_q.size() != 0) $display("FAIL scoreboard_drain: %0d left required 0", exp_q.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
